// File: rtl/checkout_register.sv
// Checkout cart accumulator: synchronises the scan button, prices each scanned
// item, keeps a saturating running total and item count, and raises alarm/full
// flags. Total is presented as two BCD digits for the seven-segment drivers.
module checkout_register #(
  parameter int MAX_ITEMS = 9,   // cart capacity, 1..15
  parameter int TOTAL_MAX = 99   // total ceiling, <= 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan,
  input  logic [2:0] item,
  input  logic       stolen,
  input  logic       discount,
  input  logic       ack,
  input  logic       clear,
  output logic [3:0] total_tens,
  output logic [3:0] total_ones,
  output logic [3:0] count,
  output logic       alarm,
  output logic       full,
  output logic       err,
  output logic       ovf
);

  typedef enum logic [1:0] {SHOP, ALARM, FULL} state_t;

  state_t     state, state_next;
  logic       s1, s2, s3;
  logic       scan_edge;
  logic [6:0] total, total_next;
  logic [3:0] count_next;
  logic       ovf_next, err_next;
  logic [3:0] price;
  logic       price_ok;
  logic [3:0] eff;
  logic [7:0] sum;

  // Three-flop synchroniser on the asynchronous scan button; rising edge detect.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign scan_edge = s2 & ~s3;

  // Item code to dollar price; two codes are not stocked.
  always_comb begin
    price    = 4'd0;
    price_ok = 1'b1;
    case (item)
      3'b000:  price = 4'd9;
      3'b001:  price = 4'd4;
      3'b011:  price = 4'd7;
      3'b100:  price = 4'd2;
      3'b101:  price = 4'd8;
      3'b110:  price = 4'd5;
      default: price_ok = 1'b0;
    endcase
  end

  // Discounted items cost half, rounded down; the sum has headroom above 99.
  assign eff = discount ? (price >> 1) : price;
  assign sum = {1'b0, total} + {4'b0000, eff};

  // Next-state and cart update; clear has priority over ack and any scan edge.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    total_next = total;
    count_next = count;
    ovf_next   = ovf;
    err_next   = 1'b0;
    if (clear) begin
      state_next = SHOP;
      total_next = 7'd0;
      count_next = 4'd0;
      ovf_next   = 1'b0;
    end else begin
      case (state)
        SHOP: begin
          if (scan_edge) begin
            if (!price_ok) begin
              err_next = 1'b1;
            end else if (stolen) begin
              state_next = ALARM;
            end else begin
              count_next = count + 4'd1;
              if (sum > 8'(TOTAL_MAX)) begin
                total_next = 7'(TOTAL_MAX);
                ovf_next   = 1'b1;
              end else begin
                total_next = sum[6:0];
              end
              if (count_next == 4'(MAX_ITEMS)) state_next = FULL;
            end
          end
        end
        ALARM: begin
          if (ack)       state_next = SHOP;
          if (scan_edge) err_next   = 1'b1;
        end
        FULL: begin
          if (scan_edge) err_next = 1'b1;
        end
        default: state_next = SHOP;
      endcase
    end
  end

  // State and cart registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOP;
      total <= 7'd0;
      count <= 4'd0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      total <= total_next;
      count <= count_next;
      ovf   <= ovf_next;
      err   <= err_next;
    end
  end

  assign alarm      = (state == ALARM);
  assign full       = (state == FULL);
  assign total_tens = 4'(total / 7'd10);
  assign total_ones = 4'(total % 7'd10);

endmodule

// File: tb/tb_checkout_register.sv
// Scoreboard bench for checkout_register. Stimulus tasks push the expected
// output vector and the cycle it must appear on; a monitor pops an entry every
// time the DUT output vector changes and compares value and timing.
module tb_checkout_register;

  logic       clk = 1'b0;
  logic       reset, scan, stolen, discount, ack, clear;
  logic [2:0] item;
  logic [3:0] total_tens, total_ones, count;
  logic       alarm, full, err, ovf;

  // MAX_ITEMS raised to 12 so that the 99 ceiling is reachable with $9 items.
  checkout_register #(.MAX_ITEMS(12), .TOTAL_MAX(99)) dut (
    .clk(clk), .reset(reset), .scan(scan), .item(item), .stolen(stolen),
    .discount(discount), .ack(ack), .clear(clear),
    .total_tens(total_tens), .total_ones(total_ones), .count(count),
    .alarm(alarm), .full(full), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        mon_en = 1'b0;
  logic [15:0] obs, prev;

  // Expected cart as written by the directed sequence (hand-computed values).
  int   c_tot = 0, c_cnt = 0;
  logic c_al = 1'b0, c_fu = 1'b0, c_ov = 1'b0;

  assign obs = {total_tens, total_ones, count, alarm, full, err, ovf};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] snap(input logic e);
    return {4'(c_tot / 10), 4'(c_tot % 10), 4'(c_cnt), c_al, c_fu, e, c_ov};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change in the output vector must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && obs !== prev) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_change: got %h, expected no change (cycle %0d)", obs, cyc);
      end else begin
        e = sb.pop_front();
        check("out_value", int'(obs), int'(e.val));
        check("out_cycle", cyc, e.cyc);
      end
    end
    prev = obs;
  end

  // One scan press. kind: 0 no visible effect, 1 cart/state change, 2 err pulse.
  // side_ack/side_clr are asserted for the cycle in which the edge is consumed.
  task automatic press(input logic [2:0] code, input logic st, input logic dc,
                       input int kind, input int hold,
                       input logic side_ack, input logic side_clr);
    int n;
    @(negedge clk);
    item = code; stolen = st; discount = dc; scan = 1'b1;
    n = cyc;
    if (kind == 1) begin
      sb.push_back('{n + 3, snap(1'b0)});
    end else if (kind == 2) begin
      sb.push_back('{n + 3, snap(1'b1)});
      sb.push_back('{n + 4, snap(1'b0)});
    end
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == 2) begin ack = side_ack; clear = side_clr; end
      if (i == 3) begin ack = 1'b0; clear = 1'b0; end
    end
    scan = 1'b0; stolen = 1'b0; discount = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One-cycle ack/clear pulse; the effect is visible on the next cycle.
  task automatic pulse(input logic a, input logic c, input logic change);
    @(negedge clk);
    ack = a; clear = c;
    if (change) sb.push_back('{cyc + 1, snap(1'b0)});
    @(negedge clk);
    ack = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; scan = 1'b0; item = 3'b000; stolen = 1'b0;
    discount = 1'b0; ack = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", int'(obs), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic add: $9, count 1.
    c_tot = 9; c_cnt = 1;
    press(3'b000, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0);
    c_tot = 0; c_cnt = 0;
    pulse(1'b0, 1'b1, 1'b1);

    // Discounted $8 -> $4, then $7 -> total 11.
    c_tot = 4; c_cnt = 1;
    press(3'b101, 1'b0, 1'b1, 1, 3, 1'b0, 1'b0);
    c_tot = 11; c_cnt = 2;
    press(3'b011, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0);

    // Stolen -> alarm, scan in alarm -> err, ack -> shop, next scan adds $2.
    c_al = 1'b1;
    press(3'b001, 1'b1, 1'b0, 1, 3, 1'b0, 1'b0);
    press(3'b001, 1'b0, 1'b0, 2, 3, 1'b0, 1'b0);
    c_al = 1'b0;
    pulse(1'b1, 1'b0, 1'b1);
    c_tot = 13; c_cnt = 3;
    press(3'b100, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0);

    // Invalid codes -> err only; 20-cycle hold -> a single $5 update.
    press(3'b111, 1'b0, 1'b0, 2, 3, 1'b0, 1'b0);
    press(3'b010, 1'b0, 1'b1, 2, 3, 1'b0, 1'b0);
    c_tot = 18; c_cnt = 4;
    press(3'b110, 1'b0, 1'b0, 1, 20, 1'b0, 1'b0);
    // Odd price discounted rounds down: $9 -> $4.
    c_tot = 22; c_cnt = 5;
    press(3'b000, 1'b0, 1'b1, 1, 3, 1'b0, 1'b0);

    // Ack together with an edge in alarm: leaves alarm and flags err.
    c_al = 1'b1;
    press(3'b001, 1'b1, 1'b0, 1, 3, 1'b0, 1'b0);
    c_al = 1'b0;
    press(3'b101, 1'b0, 1'b0, 2, 3, 1'b1, 1'b0);
    // Ack while shopping does nothing.
    pulse(1'b1, 1'b0, 1'b0);

    // Fill the cart: 11 x $9 lands exactly on 99 without ovf, 12th clamps.
    c_tot = 0; c_cnt = 0;
    pulse(1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      c_tot = 9 * k; c_cnt = k;
      press(3'b000, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0);
    end
    c_tot = 99; c_cnt = 12; c_fu = 1'b1; c_ov = 1'b1;
    press(3'b000, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0);
    press(3'b000, 1'b0, 1'b0, 2, 3, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    c_tot = 0; c_cnt = 0; c_fu = 1'b0; c_ov = 1'b0;
    pulse(1'b0, 1'b1, 1'b1);

    // Clear in the same cycle as an edge: cart empty, no err.
    c_tot = 2; c_cnt = 1;
    press(3'b100, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0);
    c_tot = 0; c_cnt = 0;
    press(3'b000, 1'b0, 1'b0, 1, 3, 1'b0, 1'b1);

    // Reset mid-sync with scan held; the held press lands once after release.
    c_tot = 9; c_cnt = 1;
    press(3'b000, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0);
    @(negedge clk);
    item = 3'b100; scan = 1'b1;
    n = cyc;
    @(negedge clk);
    reset = 1'b1;
    c_tot = 0; c_cnt = 0;
    sb.push_back('{n + 2, snap(1'b0)});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    c_tot = 2; c_cnt = 1;
    sb.push_back('{cyc + 3, snap(1'b0)});
    repeat (6) @(negedge clk);
    scan = 1'b0;
    repeat (5) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
